// File: rtl/dram_tester_ctrl.sv
// dram_tester_ctrl: power-on self-test sequencer for an SDRAM controller host port.
// Writes pat(a) = 16'h5A00 + a to every word of a 2^ADDR_WIDTH window, reads
// the window back, counts mismatches (saturating at 15) and shows the result
// on eight LEDs.
// Optional build macro TESTER_LOOP_EN: restart after each pass, inverting the
// pattern on alternate passes and holding the last pass/fail result on the LEDs.
module dram_tester_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int INIT_WAIT  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  rd_enable_o,
    output logic                  wr_enable_o,
    input  logic                  busy_i,
    input  logic                  rd_ready_i,
    input  logic [15:0]           rd_data_i,
    output logic [15:0]           wr_data_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [7:0]            leds_o
);

    typedef enum logic [2:0] {
        INIT_DLY,
        WR_ISSUE,
        WR_PULSE,
        WR_WAIT,
        RD_ISSUE,
        RD_PULSE,
        RD_WAIT,
        DONE
    } state_t;

    localparam int                    DLY_W     = (INIT_WAIT > 1) ? $clog2(INIT_WAIT) : 1;
    localparam logic [DLY_W-1:0]      DLY_LAST  = DLY_W'((INIT_WAIT > 0) ? INIT_WAIT - 1 : 0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = '1;

    state_t                  state_q, state_d;
    logic [DLY_W-1:0]        dly_q, dly_d;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [3:0]              err_q, err_d;
    logic                    skip_q, skip_d;   // first WR_WAIT cycle: busy_i not yet valid
    logic                    inv_q, inv_d;     // pattern inversion for odd passes
    logic                    wr_en_d, rd_en_d;
    logic [15:0]             wr_data_d;
    logic [7:0]              leds_d;
    logic                    res_pass_d, res_fail_d;

    // Expected word for an address; inversion only ever set in loop builds.
    function automatic logic [15:0] pat(input logic [ADDR_WIDTH-1:0] a, input logic inv);
        logic [15:0] p;
        p = 16'h5A00 + 16'(a);
        return inv ? ~p : p;
    endfunction

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d = state_q;
        dly_d   = dly_q;
        addr_d  = addr_o;
        err_d   = err_q;
        skip_d  = 1'b0;
        inv_d   = inv_q;
        wr_en_d = 1'b0;
        rd_en_d = 1'b0;

        case (state_q)
            INIT_DLY: begin
                if (dly_q == DLY_LAST) state_d = WR_ISSUE;
                else                   dly_d   = dly_q + 1'b1;
            end
            WR_ISSUE: begin
                if (!busy_i) begin
                    wr_en_d = 1'b1;
                    state_d = WR_PULSE;
                end
            end
            WR_PULSE: begin
                skip_d  = 1'b1;
                state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (!skip_q && !busy_i) begin
                    if (addr_o == ADDR_MAX) begin
                        addr_d  = '0;
                        state_d = RD_ISSUE;
                    end else begin
                        addr_d  = addr_o + 1'b1;
                        state_d = WR_ISSUE;
                    end
                end
            end
            RD_ISSUE: begin
                if (!busy_i) begin
                    rd_en_d = 1'b1;
                    state_d = RD_PULSE;
                end
            end
            RD_PULSE: begin
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (rd_ready_i) begin
                    if (rd_data_i != pat(addr_o, inv_q) && err_q != 4'hF)
                        err_d = err_q + 1'b1;
                    if (addr_o == ADDR_MAX) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = addr_o + 1'b1;
                        state_d = RD_ISSUE;
                    end
                end
            end
            DONE: begin
`ifdef TESTER_LOOP_EN
                state_d = WR_ISSUE;
                addr_d  = '0;
                err_d   = 4'h0;
                inv_d   = ~inv_q;
`endif
            end
            default: state_d = INIT_DLY;
        endcase

        wr_data_d = pat(addr_d, inv_d);

`ifdef TESTER_LOOP_EN
        // Result LEDs latch on entry to DONE and hold through the next pass.
        res_pass_d = leds_o[2];
        res_fail_d = leds_o[3];
        if (state_d == DONE) begin
            res_pass_d = (err_d == 4'h0);
            res_fail_d = (err_d != 4'h0);
        end
`else
        res_pass_d = (state_d == DONE) && (err_d == 4'h0);
        res_fail_d = (state_d == DONE) && (err_d != 4'h0);
`endif

        leds_d[0]   = (state_d == WR_ISSUE) || (state_d == WR_PULSE) || (state_d == WR_WAIT);
        leds_d[1]   = (state_d == RD_ISSUE) || (state_d == RD_PULSE) || (state_d == RD_WAIT);
        leds_d[2]   = res_pass_d;
        leds_d[3]   = res_fail_d;
        leds_d[7:4] = err_d;
    end

    // State and registered outputs; reset aborts any pulse immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= INIT_DLY;
            dly_q       <= '0;
            err_q       <= 4'h0;
            skip_q      <= 1'b0;
            inv_q       <= 1'b0;
            rd_enable_o <= 1'b0;
            wr_enable_o <= 1'b0;
            wr_data_o   <= 16'h0000;
            addr_o      <= '0;
            leds_o      <= 8'h00;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            dly_q       <= dly_d;
            err_q       <= err_d;
            skip_q      <= skip_d;
            inv_q       <= inv_d;
            rd_enable_o <= rd_en_d;
            wr_enable_o <= wr_en_d;
            wr_data_o   <= wr_data_d;
            addr_o      <= addr_d;
            leds_o      <= leds_d;
        end
    end

endmodule

// File: tb/tb_dram_tester_ctrl.sv
// Testbench for dram_tester_ctrl: a simple controller/memory model with a
// 3-cycle busy window per request, a protocol monitor, and directed scenarios
// with hand-computed LED results.
module tb_dram_tester_ctrl;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rd_enable_o, wr_enable_o;
    logic          busy_i;
    logic          rd_ready_i = 1'b0;
    logic [15:0]   rd_data_i  = 16'h0000;
    logic [15:0]   wr_data_o;
    logic [AW-1:0] addr_o;
    logic [7:0]    leds_o;

    logic busy_m     = 1'b0;
    logic busy_force = 1'b0;
    assign busy_i = busy_m | busy_force;

    int n_checks = 0;
    int n_errors = 0;

    // Model controls and statistics.
    int          mode = 0;       // 0 ideal, 1 corrupt addr 3, 2 corrupt all
    bit          spur = 1'b0;    // inject stray rd_ready after each write
    logic [15:0] mem [16];
    int          wr_cnt, rd_cnt, wr_bad, rd_bad, seq_bad;
    int          both_viol, busy_viol, stab_viol;

    dram_tester_ctrl #(.ADDR_WIDTH(AW), .INIT_WAIT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_enable_o (rd_enable_o),
        .wr_enable_o (wr_enable_o),
        .busy_i      (busy_i),
        .rd_ready_i  (rd_ready_i),
        .rd_data_i   (rd_data_i),
        .wr_data_o   (wr_data_o),
        .addr_o      (addr_o),
        .leds_o      (leds_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Controller/memory model and protocol monitor, evaluated on falling edges.
    initial begin
        bit            wr_prev = 1'b0, rd_prev = 1'b0;
        bit            active = 1'b0, is_wr = 1'b0, rd_pend = 1'b0;
        int            bcnt = 0;
        logic [AW-1:0] lat_addr = '0;
        logic [15:0]   lat_data = 16'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_m = 1'b0; rd_ready_i = 1'b0; rd_data_i = 16'h0;
                wr_prev = 1'b0; rd_prev = 1'b0; active = 1'b0; rd_pend = 1'b0; bcnt = 0;
                wr_cnt = 0; rd_cnt = 0; wr_bad = 0; rd_bad = 0; seq_bad = 0;
                both_viol = 0; busy_viol = 0; stab_viol = 0;
                continue;
            end
            rd_ready_i = 1'b0;
            if (wr_enable_o && rd_enable_o) both_viol++;
            if (((wr_enable_o && !wr_prev) || (rd_enable_o && !rd_prev)) && busy_i) busy_viol++;
            if (wr_enable_o && !wr_prev) begin
                if (addr_o != AW'(wr_cnt) || wr_data_o != 16'h5A00 + 16'(wr_cnt)) wr_bad++;
                if (rd_cnt != 0) seq_bad++;
                mem[addr_o] = wr_data_o;
                wr_cnt++;
                active = 1'b1; is_wr = 1'b1; lat_addr = addr_o; lat_data = wr_data_o;
                busy_m = 1'b1; bcnt = 3;
                if (spur) begin
                    rd_ready_i = 1'b1;
                    rd_data_i  = 16'h0000;
                end
            end else if (rd_enable_o && !rd_prev) begin
                if (addr_o != AW'(rd_cnt)) rd_bad++;
                if (wr_cnt != 16) seq_bad++;
                rd_cnt++;
                active = 1'b1; is_wr = 1'b0; lat_addr = addr_o;
                busy_m = 1'b1; bcnt = 3; rd_pend = 1'b1;
            end else begin
                if (active && (addr_o != lat_addr || (is_wr && wr_data_o != lat_data))) stab_viol++;
                if (busy_m) begin
                    bcnt--;
                    if (bcnt == 0) begin
                        busy_m = 1'b0;
                        active = 1'b0;
                        if (rd_pend) begin
                            rd_pend    = 1'b0;
                            rd_ready_i = 1'b1;
                            case (mode)
                                1:       rd_data_i = (lat_addr == AW'(3)) ? 16'h0000 : mem[lat_addr];
                                2:       rd_data_i = ~mem[lat_addr];
                                default: rd_data_i = mem[lat_addr];
                            endcase
                        end
                    end
                end
            end
            wr_prev = wr_enable_o;
            rd_prev = rd_enable_o;
        end
    end

    task automatic do_reset();
        @(negedge clk); #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
    endtask

    // Edges from now until the first write pulse is visible.
    task automatic wait_first_wr(input string tag, input int exp_cycles);
        int n = 0;
        while (!wr_enable_o && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, n, exp_cycles);
        check({tag, "_addr0"},   32'(addr_o), 32'h0);
        check({tag, "_data0"},   32'(wr_data_o), 32'h5A00);
        check({tag, "_leds_wr"}, 32'(leds_o), 32'h01);
    endtask

    task automatic wait_done(input string tag, input logic [7:0] exp_leds);
        int n = 0;
        while (!(leds_o[2] || leds_o[3]) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 32'(leds_o[2] || leds_o[3]), 32'h1);
        check({tag, "_leds"},      32'(leds_o), 32'(exp_leds));
        check({tag, "_addr_max"},  32'(addr_o), 32'hF);
    endtask

    task automatic check_proto(input string tag);
        check({tag, "_both_high"},  both_viol, 0);
        check({tag, "_busy_issue"}, busy_viol, 0);
        check({tag, "_addr_stab"},  stab_viol, 0);
        check({tag, "_order"},      seq_bad,   0);
    endtask

    initial begin
        int n;

        // Reset state
        #1 rst = 1'b1;
        #1;
        check("rst_outputs", {wr_enable_o, rd_enable_o, wr_data_o, addr_o, leds_o},
              {2'b00, 16'h0000, 4'h0, 8'h00});
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        // Ideal memory, stray rd_ready during writes must be ignored
        spur = 1'b1;
        wait_first_wr("ideal", 17);
        @(posedge clk); #1;
        check("ideal_pulse_width", 32'(wr_enable_o), 32'h0);
        wait_done("ideal", 8'h04);
        check("ideal_writes", wr_cnt, 16);
        check("ideal_wr_seq", wr_bad, 0);
        check("ideal_reads",  rd_cnt, 16);
        check("ideal_rd_seq", rd_bad, 0);
        check_proto("ideal");
        repeat (10) @(negedge clk);
        check("done_hold_leds", 32'(leds_o), 32'h04);
        check("done_hold_addr", 32'(addr_o), 32'hF);
        check("done_no_req",    wr_cnt + rd_cnt, 32);
        spur = 1'b0;

        // Read of addr 3 corrupted
        mode = 1;
        do_reset();
        wait_done("bad3", 8'h18);
        check_proto("bad3");

        // Every read corrupted, count saturates
        mode = 2;
        do_reset();
        wait_done("allbad", 8'hF8);
        check("allbad_reads", rd_cnt, 16);

        // Busy held high after the initial delay
        mode = 0;
        busy_force = 1'b1;
        do_reset();
        repeat (116) begin @(posedge clk); #1; end
        check("busy_no_wr",   wr_cnt, 0);
        check("busy_wr_low",  32'(wr_enable_o), 32'h0);
        check("busy_leds",    32'(leds_o), 32'h01);
        @(negedge clk); #1 busy_force = 1'b0;
        wait_first_wr("busy_rel", 1);
        @(posedge clk); #1;
        check("busy_pulse_width", 32'(wr_enable_o), 32'h0);
        wait_done("busy_rel", 8'h04);
        check_proto("busy_rel");

        // Async reset during the read phase
        do_reset();
        n = 0;
        while (!(rd_enable_o && rd_cnt >= 5) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check("rdrst_pulse_seen", 32'(rd_enable_o), 32'h1);
        check("rdrst_leds_rd",    32'(leds_o), 32'h02);
        check_proto("rdrst_pre");
        #1 rst = 1'b1;
        #1;
        check("rdrst_async_outputs", {wr_enable_o, rd_enable_o, wr_data_o, addr_o, leds_o},
              {2'b00, 16'h0000, 4'h0, 8'h00});
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        wait_first_wr("rdrst_restart", 17);
        wait_done("rdrst", 8'h04);
        check_proto("rdrst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dram_tester_ctrl.md
Name: dram_tester_ctrl

Overview:
Self-test sequencer that sits between the board and the SDRAM controller host port. After reset it writes a deterministic pattern to every word of a 2^ADDR_WIDTH address window. It then reads the window back, compares each word against the pattern, and reports progress and pass/fail on 8 LEDs.

Parameters:
ADDR_WIDTH, 4, width of addr_o; window = 2^ADDR_WIDTH words starting at 0
INIT_WAIT, 16, clock cycles to wait after reset before the first access (in addition to waiting for busy_i low)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
rd_enable_o  out  1  read request pulse to controller
wr_enable_o  out  1  write request pulse to controller
busy_i  in  1  controller busy; no request may be issued while high
rd_ready_i  in  1  controller read-data-valid strobe
rd_data_i  in  16  read data from controller
wr_data_o  out  16  write data to controller
addr_o  out  ADDR_WIDTH  word address, same bus used for reads and writes
leds_o  out  8  status

Behaviour:
- All outputs are registered. On rst (async): rd_enable_o=0, wr_enable_o=0, wr_data_o=0, addr_o=0, leds_o=0, error count=0, state=INIT_DLY, delay counter=0. Asserting rst mid-operation aborts immediately to this state; no request pulse may extend past reset.
- Pattern: pat(a) = 16'h5A00 + zero-extended a, truncated to 16 bits. wr_data_o always equals pat(addr_o) while in the write phase.
- States:
  - INIT_DLY: count INIT_WAIT cycles, then go to WR_ISSUE.
  - WR_ISSUE: when busy_i=0, set wr_enable_o=1 and go to WR_PULSE.
  - WR_PULSE: clear wr_enable_o, go to WR_WAIT. The enable is high exactly 1 cycle.
  - WR_WAIT: ignore busy_i in the first cycle. Afterwards, when busy_i=0: if addr_o=max, set addr_o=0 and go to RD_ISSUE; otherwise set addr_o+1 and go to WR_ISSUE.
  - RD_ISSUE: when busy_i=0, set rd_enable_o=1 and go to RD_PULSE.
  - RD_PULSE: clear rd_enable_o, go to RD_WAIT.
  - RD_WAIT: wait for rd_ready_i=1, with no timeout (hangs if it never arrives). On that cycle compare rd_data_i with pat(addr_o); on mismatch, error count +1, saturating at 15. Then if addr_o=max go to DONE, otherwise set addr_o+1 and go to RD_ISSUE.
  - DONE: terminal; outputs hold; addr_o stays at max.
- addr_o and wr_data_o remain stable from the ISSUE state until the WAIT state exits.
- rd_enable_o and wr_enable_o are never high in the same cycle.
- rd_ready_i outside RD_WAIT is ignored.
- LEDs:
  - leds_o[0] = 1 in any write state.
  - leds_o[1] = 1 in any read state.
  - leds_o[2] = 1 in DONE with error count 0 (pass).
  - leds_o[3] = 1 in DONE with error count > 0 (fail).
  - leds_o[7:4] = error count (live).
  - leds_o is updated on the same edge as the state change.

Optional Feature:
TESTER_LOOP_EN
- Defined: DONE lasts 1 cycle, then the tester restarts at WR_ISSUE with addr 0 and error count cleared. The pattern is XORed with 16'hFFFF on every odd pass, toggled per completed pass. leds_o[2]/[3] hold the previous pass result until the next DONE.
- Not defined: DONE is terminal until reset.

Test Plan:
- ADDR_WIDTH=4, ideal memory/controller model -> 16 writes at addr 0..15 with data 16'h5A00..16'h5A0F, then 16 reads; final leds_o=8'h04.
- Same setup, model corrupts read of addr 3 (returns 16'h0000) -> final leds_o=8'h18 (count 1, fail).
- Every read returns the wrong value -> count saturates; final leds_o=8'hF8.
- busy_i held high for 100 cycles after INIT_DLY -> no wr_enable_o pulse. First pulse occurs 1 cycle after busy_i falls, width 1 cycle, with addr_o=0 and wr_data_o=16'h5A00.
- rst asserted during the read phase -> all outputs 0 immediately (async), without waiting for a clock edge. After release the sequence restarts from INIT_DLY with a write to addr 0.
- Protocol check over the full run: wr_enable_o and rd_enable_o never both high; never asserted while busy_i=1 was sampled in the issuing cycle; addr_o stable from pulse to completion.
